aes_decrypt: RTL and testbench

- 16-bit simplified-AES (nibble AES) decryptor; inverse of the team's `AES` encryptor. Sits on the receive side of the link.
- Takes a ciphertext block, the cipher key, an initialisation vector and a round count. Returns the plaintext block, CBC-unchained: P = D_K(C) xor IV.
- Multi-cycle FSM plus datapath. Round keys are expanded forward once, then walked backward with the inverse key schedule.

---
 rtl/aes_decrypt.sv | 216 +++++++++++++++++++++
 tb/tb_aes_decrypt.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt.sv
// aes_decrypt: 16-bit nibble-AES decryptor, P = D_K(C) ^ IV, multi-cycle FSM.
// Ports: clk, nrst (async low), load, data_input (C), input_vector (IV),
//   key (K0), round_number (N) -> data_output (P), finish (pulse), busy.
// Optional `AES_DEC_CBC_CHAIN_EN adds input chain: IV = previous block's C.
module aes_decrypt (
  input  logic        clk,
  input  logic        nrst,
  input  logic        load,
  input  logic [15:0] data_input,
  input  logic [15:0] input_vector,
  input  logic [15:0] key,
  input  logic [3:0]  round_number,
  output logic [15:0] data_output,
  output logic        finish,
  output logic        busy
`ifdef AES_DEC_CBC_CHAIN_EN
  ,
  input  logic        chain
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    ADDK,
    ISR,
    INS,
    ARK,
    IMC,
    DONE
  } state_e;

  // Nibble tables, entry 0 in the top nibble.
  localparam logic [63:0] SBOX = 64'h94AB_D185_6203_CEF7;
  localparam logic [63:0] ISBOX = 64'hA59B_178F_6023_C4DE;
  // x^(i+2) mod x^4+x+1 for i = 1..15; entry 0 unused.
  localparam logic [63:0] RCON = 64'h0836_CB5A_7EFD_9124;

  function automatic logic [3:0] tbl(
    input logic [63:0] t,
    input logic [3:0]  x
  );
    return t[6'd60 - {x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] xt(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
  endfunction

  function automatic logic [3:0] mul9(input logic [3:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  // SubNib(RotNib(w)) on one key byte.
  function automatic logic [7:0] g(input logic [7:0] w);
    return {tbl(SBOX, w[3:0]), tbl(SBOX, w[7:4])};
  endfunction

  function automatic logic [15:0] key_fwd(
    input logic [15:0] k,
    input logic [3:0]  rc
  );
    logic [7:0] w0;
    w0 = k[15:8] ^ {rc, 4'h0} ^ g(k[7:0]);
    return {w0, w0 ^ k[7:0]};
  endfunction

  function automatic logic [15:0] key_bwd(
    input logic [15:0] k,
    input logic [3:0]  rc
  );
    logic [7:0] w1;
    w1 = k[15:8] ^ k[7:0];
    return {k[15:8] ^ {rc, 4'h0} ^ g(w1), w1};
  endfunction

  function automatic logic [15:0] inv_sub(input logic [15:0] s);
    return {tbl(ISBOX, s[15:12]), tbl(ISBOX, s[11:8]),
            tbl(ISBOX, s[7:4]), tbl(ISBOX, s[3:0])};
  endfunction

  function automatic logic [15:0] inv_mix(input logic [15:0] s);
    logic [3:0] a, b, c, d;
    {a, b, c, d} = s;
    return {mul9(a) ^ xt(b), xt(a) ^ mul9(b),
            mul9(c) ^ xt(d), xt(c) ^ mul9(d)};
  endfunction

  state_e      state_q, state_d;
  logic [15:0] blk_q, blk_d;
  logic [15:0] key_q, key_d;
  logic [15:0] iv_q, iv_d;
  logic [3:0]  n_q, n_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] dout_q, dout_d;
  logic        finish_q, finish_d;
  logic        busy_q, busy_d;
  logic [15:0] key_prev;
`ifdef AES_DEC_CBC_CHAIN_EN
  logic [15:0] ct_q, ct_d;
  logic [15:0] prev_ct_q, prev_ct_d;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      blk_q     <= '0;
      key_q     <= '0;
      iv_q      <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      finish_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef AES_DEC_CBC_CHAIN_EN
      ct_q      <= '0;
      prev_ct_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      key_q     <= key_d;
      iv_q      <= iv_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      finish_q  <= finish_d;
      busy_q    <= busy_d;
`ifdef AES_DEC_CBC_CHAIN_EN
      ct_q      <= ct_d;
      prev_ct_q <= prev_ct_d;
`endif
    end
  end

  // cnt_q is the forward step index in KEYEXP and the round r afterwards.
  assign key_prev = key_bwd(key_q, tbl(RCON, cnt_q));

  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    key_d     = key_q;
    iv_d      = iv_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    finish_d  = 1'b0;
    busy_d    = busy_q;
`ifdef AES_DEC_CBC_CHAIN_EN
    ct_d      = ct_q;
    prev_ct_d = prev_ct_q;
`endif
    unique case (state_q)
      IDLE: begin
        // The finish cycle is spent here; load is not taken until busy clears.
        if (finish_q) begin
          busy_d = 1'b0;
        end else if (load) begin
          blk_d  = data_input;
          key_d  = key;
          n_d    = round_number;
          cnt_d  = 4'd1;
          busy_d = 1'b1;
          iv_d   = input_vector;
`ifdef AES_DEC_CBC_CHAIN_EN
          ct_d   = data_input;
          if (chain) iv_d = prev_ct_q;
`endif
          state_d = (round_number == 4'd0) ? ADDK : KEYEXP;
        end
      end
      KEYEXP: begin
        key_d = key_fwd(key_q, tbl(RCON, cnt_q));
        if (cnt_q == n_q) state_d = ADDK;
        else cnt_d = cnt_q + 4'd1;
      end
      ADDK: begin
        blk_d   = blk_q ^ key_q;
        cnt_d   = n_q;
        state_d = (n_q == 4'd0) ? DONE : ISR;
      end
      ISR: begin
        blk_d   = {blk_q[15:12], blk_q[3:0], blk_q[7:4], blk_q[11:8]};
        state_d = INS;
      end
      INS: begin
        blk_d   = inv_sub(blk_q);
        state_d = ARK;
      end
      ARK: begin
        key_d   = key_prev;
        blk_d   = blk_q ^ key_prev;
        state_d = (cnt_q == 4'd1) ? DONE : IMC;
      end
      IMC: begin
        blk_d   = inv_mix(blk_q);
        cnt_d   = cnt_q - 4'd1;
        state_d = ISR;
      end
      DONE: begin
        dout_d    = blk_q ^ iv_q;
        finish_d  = 1'b1;
        state_d   = IDLE;
`ifdef AES_DEC_CBC_CHAIN_EN
        prev_ct_d = ct_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_output = dout_q;
  assign finish      = finish_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_aes_decrypt.sv
// tb_aes_decrypt: scoreboard bench for aes_decrypt.
// Stimulus pushes expected plaintext/latency; a monitor checks on finish.
module tb_aes_decrypt;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_input = '0;
  logic [15:0] input_vector = '0;
  logic [15:0] key = '0;
  logic [3:0]  round_number = '0;
  logic [15:0] data_output;
  logic        finish;
  logic        busy;

  always #5 clk = ~clk;

  aes_decrypt dut (
    .clk(clk),
    .nrst(nrst),
    .load(load),
    .data_input(data_input),
    .input_vector(input_vector),
    .key(key),
    .round_number(round_number),
    .data_output(data_output),
    .finish(finish),
    .busy(busy)
  );

  typedef struct {
    logic [15:0] data;
    int          lat;
    int          t0;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   blk_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] req
  );
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: every finish pulse must match the oldest outstanding block.
  initial begin
    forever begin
      @(negedge clk);
      if (nrst && finish) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_finish: finish=1 at cycle %0d, required 0",
                   cyc);
        end else begin
          e = sb.pop_front();
          chk($sformatf("blk%0d_data", e.id), 32'(data_output),
              32'(e.data));
          chk($sformatf("blk%0d_latency", e.id), 32'(cyc - e.t0),
              32'(e.lat));
        end
      end
    end
  end

  // Called at a negedge: the next posedge is the load edge.
  task automatic start(
    input logic [15:0] c,
    input logic [15:0] k,
    input logic [15:0] iv,
    input logic [3:0]  n,
    input logic [15:0] p,
    input int          lat
  );
    exp_t x;
    data_input   = c;
    key          = k;
    input_vector = iv;
    round_number = n;
    load         = 1'b1;
    blk_id++;
    x.data = p;
    x.lat  = lat;
    x.t0   = cyc + 1;
    x.id   = blk_id;
    sb.push_back(x);
    @(negedge clk);
    load = 1'b0;
    chk($sformatf("blk%0d_busy_after_load", blk_id), 32'(busy), 32'd1);
    // Captured values must be immune to later input changes.
    data_input   = 16'($urandom);
    key          = 16'($urandom);
    input_vector = 16'($urandom);
    round_number = 4'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    tests++;
    if (i >= budget) begin
      fails++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d, required idle",
               busy, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int i;
    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(data_output), 32'h0);
    chk("rst_finish", 32'(finish), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_dout", 32'(data_output), 32'h0);
    chk("post_rst_finish", 32'(finish), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);

    // Plain two-round decrypt.
    start(16'h0738, 16'hA73B, 16'h0000, 4'd2, 16'h6F6B, 11);
    wait_idle(100);
    // IV applied.
    start(16'h0738, 16'hA73B, 16'h1234, 4'd2, 16'h7D5F, 11);
    wait_idle(100);
    // Zero rounds: C ^ K ^ IV.
    start(16'hFFFF, 16'h00FF, 16'h0F0F, 4'd0, 16'hF00F, 2);
    wait_idle(100);
    // Single round, no InvMixCol.
    start(16'h0738, 16'hA73B, 16'h0000, 4'd1, 16'hF968, 6);
    wait_idle(100);

    // Load pulsed while busy is ignored.
    start(16'h0738, 16'hA73B, 16'h0000, 4'd2, 16'h6F6B, 11);
    repeat (3) @(negedge clk);
    data_input   = 16'hFFFF;
    key          = 16'h00FF;
    input_vector = 16'h0F0F;
    round_number = 4'd0;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_idle(100);
    repeat (4) @(negedge clk);
    chk("dout_hold", 32'(data_output), 32'h6F6B);

    // Load held through the finish cycle is taken one cycle later.
    start(16'hFFFF, 16'h00FF, 16'h0F0F, 4'd0, 16'hF00F, 2);
    for (i = 0; i < 20 && !finish; i++) @(negedge clk);
    chk("finish_seen", 32'(finish), 32'h1);
    data_input   = 16'h0738;
    key          = 16'hA73B;
    input_vector = 16'h1234;
    round_number = 4'd1;
    load = 1'b1;
    blk_id++;
    e.data = 16'hEB5C;
    e.lat  = 6;
    e.t0   = cyc + 2;
    e.id   = blk_id;
    sb.push_back(e);
    @(negedge clk);
    chk("finish_cycle_busy_low", 32'(busy), 32'h0);
    @(negedge clk);
    load = 1'b0;
    chk("retry_busy", 32'(busy), 32'h1);
    wait_idle(100);

    // Reset in the middle of key expansion aborts the block.
    start(16'h0738, 16'hA73B, 16'h0000, 4'd10, 16'h0000, 51);
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_dout", 32'(data_output), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    nrst = 1'b1;
    repeat (60) @(negedge clk);
    chk("abort_idle", 32'(busy), 32'h0);
    start(16'h0738, 16'hA73B, 16'h0000, 4'd2, 16'h6F6B, 11);
    wait_idle(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
